// File: rtl/regfile_param_pc.sv
// Parametrised register file with a PC register in the top slot,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_param_pc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PC_STEP = 4,
  parameter int BYPASS  = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [DATA_W-1:0]        WD,
  input  logic [ADDR_W-1:0]        A,
  input  logic [ADDR_W-1:0]        B,
  output logic [DATA_W-1:0]        PA,
  output logic [DATA_W-1:0]        PB,
  input  logic                     PC_LD,
  input  logic [DATA_W-1:0]        PC_IN,
  input  logic                     PC_INC,
  output logic [DATA_W-1:0]        PC_OUT,
  input  logic                     MARK,
  input  logic [ADDR_W-1:0]        MA,
  output logic                     HAZ_A,
  output logic                     HAZ_B,
  output logic [(1<<ADDR_W)-1:0]   PEND
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PCI = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic              w_byp_a;
  logic              w_byp_b;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (WE && (WA != PCI)) r_regs[WA] <= WD;
      // Load beats write-port, write-port beats increment.
      if (PC_LD)
        r_regs[PCI] <= PC_IN;
      else if (WE && (WA == PCI))
        r_regs[PCI] <= WD;
      else if (PC_INC)
        r_regs[PCI] <= r_regs[PCI] + DATA_W'(PC_STEP);
    end
  end

  assign w_set = MARK ? (NREG'(1) << MA) : '0;
  assign w_clr = WE ? (NREG'(1) << WA) : '0;

  // A new producer (set) outranks a retiring one (clear).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_set;
  end

  assign w_byp_a = (BYPASS != 0) && WE && (WA == A);
  assign w_byp_b = (BYPASS != 0) && WE && (WA == B);

  assign PA = !RESET ? '0 : (w_byp_a ? WD : r_regs[A]);
  assign PB = !RESET ? '0 : (w_byp_b ? WD : r_regs[B]);

  assign PC_OUT = r_regs[PCI];
  assign PEND   = r_pend;

  assign HAZ_A = RESET && r_pend[A] && !w_byp_a;
  assign HAZ_B = RESET && r_pend[B] && !w_byp_b;

endmodule

// File: tb/tb_regfile_param_pc.sv
// Bench for regfile_param_pc: four parameter variants driven in
// lockstep and compared against an array-based reference model.
module tb_regfile_param_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we, pc_ld, pc_inc, mark;
  logic [3:0]  wa, a, b, ma;
  logic [31:0] wd, pc_in;

  logic [31:0] pa [3];
  logic [31:0] pb [3];
  logic [31:0] pco [3];
  logic        hza [3];
  logic        hzb [3];
  logic [15:0] pnd [3];
  logic [15:0] pa3, pb3, pco3;
  logic        hza3, hzb3;
  logic [7:0]  pnd3;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_reg [4][16];
  logic [15:0] m_pend [4];

  always #5 clk = ~clk;

  regfile_param_pc u0 (
    .CLK(clk), .RESET(rst), .WE(we), .WA(wa), .WD(wd),
    .A(a), .B(b), .PA(pa[0]), .PB(pb[0]),
    .PC_LD(pc_ld), .PC_IN(pc_in), .PC_INC(pc_inc), .PC_OUT(pco[0]),
    .MARK(mark), .MA(ma), .HAZ_A(hza[0]), .HAZ_B(hzb[0]), .PEND(pnd[0])
  );

  regfile_param_pc #(.BYPASS(0)) u1 (
    .CLK(clk), .RESET(rst), .WE(we), .WA(wa), .WD(wd),
    .A(a), .B(b), .PA(pa[1]), .PB(pb[1]),
    .PC_LD(pc_ld), .PC_IN(pc_in), .PC_INC(pc_inc), .PC_OUT(pco[1]),
    .MARK(mark), .MA(ma), .HAZ_A(hza[1]), .HAZ_B(hzb[1]), .PEND(pnd[1])
  );

  regfile_param_pc #(.PC_STEP(8)) u2 (
    .CLK(clk), .RESET(rst), .WE(we), .WA(wa), .WD(wd),
    .A(a), .B(b), .PA(pa[2]), .PB(pb[2]),
    .PC_LD(pc_ld), .PC_IN(pc_in), .PC_INC(pc_inc), .PC_OUT(pco[2]),
    .MARK(mark), .MA(ma), .HAZ_A(hza[2]), .HAZ_B(hzb[2]), .PEND(pnd[2])
  );

  regfile_param_pc #(.DATA_W(16), .ADDR_W(3)) u3 (
    .CLK(clk), .RESET(rst), .WE(we), .WA(wa[2:0]), .WD(wd[15:0]),
    .A(a[2:0]), .B(b[2:0]), .PA(pa3), .PB(pb3),
    .PC_LD(pc_ld), .PC_IN(pc_in[15:0]), .PC_INC(pc_inc), .PC_OUT(pco3),
    .MARK(mark), .MA(ma[2:0]), .HAZ_A(hza3), .HAZ_B(hzb3), .PEND(pnd3)
  );

  function automatic logic [3:0] amask(int k);
    return (k == 3) ? 4'h7 : 4'hF;
  endfunction

  function automatic logic [31:0] dmask(int k);
    return (k == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pstep(int k);
    return (k == 2) ? 32'd8 : 32'd4;
  endfunction

  function automatic bit byp(int k, logic [3:0] ad);
    return (k != 1) && we && ((wa & amask(k)) == (ad & amask(k)));
  endfunction

  function automatic logic [31:0] m_rd(int k, logic [3:0] ad);
    if (!rst) return 32'h0;
    if (byp(k, ad)) return wd & dmask(k);
    return m_reg[k][ad & amask(k)];
  endfunction

  function automatic logic m_haz(int k, logic [3:0] ad);
    return rst && m_pend[k][ad & amask(k)] && !byp(k, ad);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 16; r++) m_reg[k][r] = 32'h0;
      m_pend[k] = 16'h0;
    end
  endtask

  task automatic m_edge();
    logic [3:0]  pci, aw, mm;
    logic [31:0] dm;
    if (!rst) return;
    for (int k = 0; k < 4; k++) begin
      pci = amask(k);
      dm  = dmask(k);
      aw  = wa & pci;
      mm  = ma & pci;
      if (pc_ld)
        m_reg[k][pci] = pc_in & dm;
      else if (we && aw == pci)
        m_reg[k][pci] = wd & dm;
      else if (pc_inc)
        m_reg[k][pci] = (m_reg[k][pci] + pstep(k)) & dm;
      if (we && aw != pci) m_reg[k][aw] = wd & dm;
      if (we)   m_pend[k][aw] = 1'b0;
      if (mark) m_pend[k][mm] = 1'b1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_pa, o_pb, o_pc, o_pn;
    logic        o_ha, o_hb;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        o_pa = {16'h0, pa3};  o_pb = {16'h0, pb3};
        o_pc = {16'h0, pco3}; o_pn = {24'h0, pnd3};
        o_ha = hza3;          o_hb = hzb3;
      end else begin
        o_pa = pa[k];  o_pb = pb[k];
        o_pc = pco[k]; o_pn = {16'h0, pnd[k]};
        o_ha = hza[k]; o_hb = hzb[k];
      end
      chk($sformatf("u%0d.PA", k), o_pa, m_rd(k, a));
      chk($sformatf("u%0d.PB", k), o_pb, m_rd(k, b));
      chk($sformatf("u%0d.PC_OUT", k), o_pc,
          rst ? m_reg[k][amask(k)] : 32'h0);
      chk($sformatf("u%0d.HAZ_A", k), {31'h0, o_ha}, {31'h0, m_haz(k, a)});
      chk($sformatf("u%0d.HAZ_B", k), {31'h0, o_hb}, {31'h0, m_haz(k, b)});
      chk($sformatf("u%0d.PEND", k), o_pn,
          {16'h0, m_pend[k] & ((k == 3) ? 16'h00FF : 16'hFFFF)});
    end
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; a = 0; b = 0;
    pc_ld = 0; pc_in = 0; pc_inc = 0; mark = 0; ma = 0;
  endtask

  task automatic settle();
    #2;
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  logic [31:0] pc_seq [3];

  initial begin
    idle();
    m_reset();
    #1;
    check_all();
    chk("rst_pc_init", pco[0], 32'h0);
    #2 rst = 1'b1;
    edge_step();

    // reg3 written, then reset dropped between edges
    we = 1; wa = 3; wd = 32'hDEAD_BEEF;
    cyc();
    idle();
    a = 3;
    settle();
    chk("pre_rst_pa", pa[0], 32'hDEAD_BEEF);
    rst = 1'b0;
    m_reset();
    #1;
    chk("rst_pa", pa[0], 32'h0);
    chk("rst_pend", {16'h0, pnd[0]}, 32'h0);
    check_all();
    #1 rst = 1'b1;
    edge_step();

    for (int i = 0; i < 15; i++) begin
      we = 1; wa = 4'(i); wd = 32'h1000_0000 + i;
      cyc();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      a = 4'(i); b = 4'(14 - i);
      settle();
      chk("rd_pa_b1", pa[0], 32'h1000_0000 + i);
      chk("rd_pb_b0", pb[1], 32'h1000_0000 + 14 - i);
      edge_step();
    end

    we = 1; wa = 5; a = 5; wd = 32'h55;
    settle();
    chk("byp1_same_cycle", pa[0], 32'h55);
    chk("byp0_old_value", pa[1], 32'h1000_0005);
    edge_step();
    idle(); a = 5;
    settle();
    chk("byp0_next_cycle", pa[1], 32'h55);
    edge_step();

    pc_seq[0] = 32'hFFFF_FFFC;
    pc_seq[1] = 32'h0000_0000;
    pc_seq[2] = 32'h0000_0004;
    pc_ld = 1; pc_in = 32'hFFFF_FFF8;
    cyc();
    pc_ld = 0; pc_inc = 1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("pc_inc_seq", pco[0], pc_seq[j]);
      if (j == 1) chk("pc16_wrap", {16'h0, pco3}, 32'h0);
    end
    idle();
    pc_ld = 1; pc_in = 32'h0000_1234; we = 1; wa = 15; wd = 32'h20;
    cyc();
    chk("pc_ld_over_we", pco[0], 32'h0000_1234);

    idle(); mark = 1; ma = 7;
    cyc();
    idle(); a = 7;
    settle();
    chk("haz_marked", {31'h0, hza[0]}, 32'h1);
    edge_step();
    we = 1; wa = 7; wd = 32'h77; a = 7;
    settle();
    chk("haz_bypassed", {31'h0, hza[0]}, 32'h0);
    chk("haz_no_bypass", {31'h0, hza[1]}, 32'h1);
    edge_step();
    idle();
    settle();
    chk("pend7_cleared", {31'h0, pnd[0][7]}, 32'h0);
    edge_step();
    we = 1; wa = 9; wd = 32'h99; mark = 1; ma = 9;
    cyc();
    idle();
    settle();
    chk("pend_set_wins", {31'h0, pnd[0][9]}, 32'h1);
    edge_step();

    we = 1; wa = 15; wd = 32'h0000_ABCD; pc_inc = 1;
    cyc();
    chk("we_over_inc", pco[0], 32'h0000_ABCD);
    idle(); pc_inc = 1;
    cyc();
    chk("inc_step4", pco[0], 32'h0000_ABD1);
    chk("inc_step8", pco[2], 32'h0000_ABD5);
    idle();

    for (int n = 0; n < 600; n++) begin
      we     = ($urandom_range(0, 2) != 0);
      wa     = 4'($urandom);
      wd     = $urandom;
      a      = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      b      = 4'($urandom);
      pc_ld  = ($urandom_range(0, 9) == 0);
      pc_in  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                           : $urandom;
      pc_inc = ($urandom_range(0, 1) == 0);
      mark   = ($urandom_range(0, 1) == 0);
      ma     = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b0;
        m_reset();
        #1;
        check_all();
        #1 rst = 1'b1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param_pc.md
Name: regfile_param_pc

Overview:
Parametrised successor to the 16x32 datapath register file. It provides 2^ADDR_W registers of DATA_W bits, two combinational read ports and one synchronous write port. Optional write-to-read bypass is selectable by parameter. The top register is a dedicated program counter with load and auto-increment, and a per-register pending-write scoreboard reports read hazards to the control unit. It sits between the decode stage (read addresses, pending marks) and the writeback stage (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, address width; register count NREG = 2^ADDR_W
PC_STEP, 4, increment applied to the PC register on PC_INC
BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = read returns stored value

Ports:
CLK  in  1  clock, rising edge active
RESET  in  1  asynchronous, active-low reset
WE  in  1  write enable
WA  in  ADDR_W  write address
WD  in  DATA_W  write data
A  in  ADDR_W  read address, port A
B  in  ADDR_W  read address, port B
PA  out  DATA_W  read data, port A
PB  out  DATA_W  read data, port B
PC_LD  in  1  load PC register from PC_IN
PC_IN  in  DATA_W  PC load value
PC_INC  in  1  advance PC register by PC_STEP
PC_OUT  out  DATA_W  current PC register value (registered)
MARK  in  1  set pending bit of register MA
MA  in  ADDR_W  register to mark pending
HAZ_A  out  1  A addresses a pending register (and is not bypassed this cycle)
HAZ_B  out  1  same for B
PEND  out  NREG  pending bit vector, bit i = register i

Behaviour:
- Reset (RESET=0, async): all registers cleared to 0, including PC. PEND cleared to 0. PA, PB, PC_OUT and HAZ_A/B are all 0 while in reset.
- Register PCI = NREG-1 is the PC register. All other registers are general purpose.
- Write: on a rising edge with WE=1, reg[WA] <= WD.
- Read: PA = reg[A] and PB = reg[B], purely combinational.
- Bypass (BYPASS=1): if WE=1 and WA==A, then PA = WD in the same cycle (likewise PB). With BYPASS=0, the new value is visible from the cycle after the edge.
- PC update priority at each edge, highest first:
  - PC_LD: reg[PCI] <= PC_IN
  - WE with WA==PCI: reg[PCI] <= WD
  - PC_INC: reg[PCI] <= reg[PCI] + PC_STEP, modulo 2^DATA_W (wraps, no flag)
  - otherwise hold
- Bypass to PCI reads forwards only the WE path, never PC_LD or PC_INC results. PC_OUT shows the registered value.
- Scoreboard, per edge for each register i:
  - WE and WA==i clears pend[i].
  - MARK and MA==i sets pend[i].
  - If both apply to the same register in the same cycle, set wins: a new producer has been issued.
- HAZ_A = pend[A] & ~(BYPASS & WE & WA==A); same form for HAZ_B. Hazard outputs are combinational.
- PC_LD and PC_INC do not touch pend[PCI]. Only the write port clears it.
- Reset asserted mid-operation overrides every other input immediately. Deassertion takes effect at the first following edge.
- Latency: write-to-read is 0 cycles with bypass, 1 cycle without. PC update is 1 cycle.
- Width rules: no sign extension, and all arithmetic is DATA_W-bit unsigned.

Test Plan:
- Reset state: drive RESET=0 mid-run after writing reg3=0xDEADBEEF, then read A=3 -> PA=0, PC_OUT=0, PEND=0, all asynchronously before the next edge.
- Write/read all registers: write reg[i]=0x1000_0000+i for i=0..14, then read pairs (A=i, B=14-i) -> PA and PB match the written values. Repeat with BYPASS=0 and 1. With WE=1, WA=A=5, WD=0x55: PA=0x55 in the same cycle iff BYPASS=1.
- PC behaviour: PC_LD with PC_IN=0xFFFFFFF8, then PC_INC for 3 cycles -> PC_OUT sequence 0xFFFFFFFC, 0x00000000, 0x00000004. PC_LD=1 with WE=1, WA=15, WD=0x20 -> PC_OUT=PC_IN.
- Scoreboard: MARK MA=7, then A=7 -> HAZ_A=1. Next cycle WE with WA=7 and BYPASS=1 -> HAZ_A=0 that cycle and pend[7]=0 after the edge. MARK and WE to the same register in one cycle -> pend stays 1.
- Simultaneous WE with WA=15 and PC_INC -> reg15=WD, no increment applied. PC_INC alone with PC_STEP=8 (parameter override) -> +8.
- DATA_W=16, ADDR_W=3 build: PEND is 8 bits, PC is reg7, and wrap at 0xFFFC+4 gives 0x0000.
